// File: rtl/seq_mul_32_pkg.sv
// Shared definitions for the sequential multiplier: state encoding, default
// width and the 4-bit carry-lookahead cell used at every level of the adder.
package seq_mul_32_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    // Result of one 4-wide lookahead cell: carries into each position plus
    // the group generate/propagate seen by the next level up.
    typedef struct packed {
        logic       gg;
        logic       pp;
        logic [3:0] c;
    } cla4_t;

    function automatic cla4_t cla4(input logic [3:0] g, input logic [3:0] p, input logic cin);
        cla4_t r;
        r.c[0] = cin;
        r.c[1] = g[0] | (p[0] & cin);
        r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.pp   = &p;
        return r;
    endfunction

endpackage

// File: rtl/mul_add32.sv
// Combinational carry-lookahead adder: 4-bit groups, super-groups of four
// groups, and a short carry chain across super-groups. Width must be a
// multiple of 16.
module mul_add32
    import seq_mul_32_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  logic [Width-1:0] x,
    input  logic [Width-1:0] y,
    input  logic             cin,
    output logic [Width-1:0] sum,
    output logic             cout
);

    localparam int NumGrp = int'(Width / 4);
    localparam int NumSup = NumGrp / 4;

    logic [Width-1:0]  bit_g;
    logic [Width-1:0]  bit_p;
    logic [Width-1:0]  bit_c;
    logic [NumGrp-1:0] grp_g;
    logic [NumGrp-1:0] grp_p;
    logic [NumGrp-1:0] grp_c;
    logic [NumSup-1:0] sup_g;
    logic [NumSup-1:0] sup_p;
    logic [NumSup:0]   sup_c;

    assign bit_g = x & y;
    assign bit_p = x ^ y;

    // Level 1: generate/propagate of each 4-bit group (independent of carry-in)
    always_comb begin
        cla4_t r;
        grp_g = '0;
        grp_p = '0;
        for (int i = 0; i < NumGrp; i++) begin
            r        = cla4(bit_g[4*i +: 4], bit_p[4*i +: 4], 1'b0);
            grp_g[i] = r.gg;
            grp_p[i] = r.pp;
        end
    end

    // Level 2: generate/propagate of each super-group of four groups
    always_comb begin
        cla4_t r;
        sup_g = '0;
        sup_p = '0;
        for (int s = 0; s < NumSup; s++) begin
            r        = cla4(grp_g[4*s +: 4], grp_p[4*s +: 4], 1'b0);
            sup_g[s] = r.gg;
            sup_p[s] = r.pp;
        end
    end

    // Carries into each super-group; only two links for a 32-bit adder
    always_comb begin
        sup_c    = '0;
        sup_c[0] = cin;
        for (int s = 0; s < NumSup; s++) begin
            sup_c[s+1] = sup_g[s] | (sup_p[s] & sup_c[s]);
        end
    end

    // Carries into each group, looked ahead from the super-group carry-in
    always_comb begin
        cla4_t r;
        grp_c = '0;
        for (int s = 0; s < NumSup; s++) begin
            r                = cla4(grp_g[4*s +: 4], grp_p[4*s +: 4], sup_c[s]);
            grp_c[4*s +: 4]  = r.c;
        end
    end

    // Carries into each bit, looked ahead from the group carry-in
    always_comb begin
        cla4_t r;
        bit_c = '0;
        for (int i = 0; i < NumGrp; i++) begin
            r                = cla4(bit_g[4*i +: 4], bit_p[4*i +: 4], grp_c[i]);
            bit_c[4*i +: 4]  = r.c;
        end
    end

    assign sum  = bit_p ^ bit_c;
    assign cout = sup_c[NumSup];

endmodule

// File: rtl/seq_mul_32.sv
// Sequential shift-and-add unsigned multiplier. One lookahead-adder pass per
// cycle over WIDTH cycles; the adder carry-out is shifted into the top of the
// accumulator so the 2*WIDTH-bit product is exact.
module seq_mul_32
    import seq_mul_32_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             last_iter;

    assign addend    = acc_lo_q[0] ? mcand_q : '0;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    mul_add32 #(
        .Width (WIDTH)
    ) u_add (
        .x    (acc_hi_q),
        .y    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // State register; reset aborts any in-flight multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, leave CALC after the final iteration,
    // leave DONE when the consumer takes the product
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StCalc;
            StCalc:  if (last_iter) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are pure decodes of the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StCalc: busy = 1'b1;
            StDone: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next values: load operands on accept, shift-add in CALC, hold otherwise
    always_comb begin
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    cnt_d    = '0;
                end
            end
            StCalc: begin
                // {cout, sum, acc_lo[W-1:1]} split back into the two halves
                acc_hi_d = {cout, sum[WIDTH-1:1]};
                acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign p = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_seq_mul_32.sv
// Self-checking bench for seq_mul_32: directed vector table, hand-written
// backpressure and reset-abort sequences, and a randomized run against a
// plain-arithmetic product model.
module tb_seq_mul_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] p;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[8];

    seq_mul_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present operands at a negedge while idle; returns edges from accept
    // (inclusive) until out_valid is seen, capped at 100.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb, output int lat);
        op_a     = ta;
        op_b     = tb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          cyc;
        int          last_acc;
        int          accepted;
        int          received;
        logic [63:0] exp_q[$];
        logic [63:0] hold_p;

        vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h0,         32'hDEAD_BEEF, 64'h0};
        vecs[3] = '{32'h1234_5678, 32'h1,         64'h0000_0000_1234_5678};
        vecs[4] = '{32'h1,         32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[6] = '{32'hFFFF_FFFF, 32'h2,         64'h0000_0001_FFFF_FFFE};
        vecs[7] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_p", p, 64'd0);
        rst_n = 1'b1;
        step();

        // Directed vectors with immediate consumption
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_p", i), p, vecs[i].p);
            check($sformatf("vec%0d_in_ready_done", i), 64'(in_ready), 64'd0);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check($sformatf("vec%0d_out_valid_after", i), 64'(out_valid), 64'd0);
            check($sformatf("vec%0d_in_ready_after", i), 64'(in_ready), 64'd1);
        end

        // Backpressure: result must hold while new operands are offered and ignored
        issue(32'hCAFE_0001, 32'h0000_0010, lat);
        check("bp_latency", 64'(lat), 64'd33);
        hold_p = 64'h0000_000C_AFE0_0010;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op_a     = $urandom;
            op_b     = $urandom;
            step();
            check("bp_p_hold", p, hold_p);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_xfer_out_valid", 64'(out_valid), 64'd0);
        check("bp_xfer_in_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_no_ghost_busy", 64'(busy), 64'd0);

        // Reset in the middle of a computation
        op_a     = 32'hABCD_1234;
        op_b     = 32'h5555_AAAA;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (11) step();
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_p", p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        issue(32'd7, 32'd6, lat);
        check("post_abort_latency", 64'(lat), 64'd33);
        check("post_abort_p", p, 64'd42);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Randomized run: in_valid held high, random consumer, scoreboard of products
        accepted = 0;
        received = 0;
        cyc      = 0;
        last_acc = 0;
        while (received < 100 && cyc < 20000) begin
            in_valid  = (accepted < 100);
            op_a      = $urandom;
            op_b      = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                if (accepted > 0) begin
                    check("rand_issue_interval_ge_34", 64'(cyc - last_acc >= 34), 64'd1);
                end
                exp_q.push_back(64'(op_a) * 64'(op_b));
                last_acc = cyc;
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_result_without_request", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("rand_product", p, exp_q.pop_front());
                end
                received++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_received", 64'(received), 64'd100);
        check("rand_accepted", 64'(accepted), 64'd100);
        check("rand_pending", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
